// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_CALC = 3'd1,
        DIV_FIX  = 3'd2,
        DIV_ZERO = 3'd3,
        DIV_DONE = 3'd4
    } div_state_e;

    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;

    // Legal builds: BPC in {1,2,4}, WIDTH >= 8 and a multiple of BPC.
    function automatic bit div_params_ok(int unsigned width, int unsigned bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) &&
               (width >= 8) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/div_iter_param_if.sv
// Request/result bundle between the EX stage and the divider.
interface div_iter_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             ack;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor, annul, ack,
        input  busy, ready, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, annul, ack,
        output busy, ready, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Partial remainder is always below the divisor, so WIDTH+1 bits cannot overflow.
    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/div_iter_param.sv
// Multi-cycle signed/unsigned restoring divider resolving BPC quotient bits per cycle.
module div_iter_param
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input logic            clk,
    input logic            rst,
    div_iter_param_if.slave bus
);
    localparam int unsigned N     = WIDTH / BPC;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam bit PARAMS_OK      = div_params_ok(WIDTH, BPC);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("div_iter_param: illegal WIDTH/BPC combination");
        end
    endgenerate

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             sgn_q, sgn_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic             neg_dsr_q, neg_dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             ready_q, ready_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;

    logic             in_neg_dvd, in_neg_dsr;
    logic [WIDTH-1:0] in_dvd_mag, in_dsr_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH-1:0] rem_chain [BPC+1];
    logic [BPC-1:0]   qbits;

    // Operand magnitudes from the live request buses.
    assign in_neg_dvd = bus.is_signed & bus.dividend[WIDTH-1];
    assign in_neg_dsr = bus.is_signed & bus.divisor[WIDTH-1];
    assign in_dvd_mag = in_neg_dvd ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign in_dsr_mag = in_neg_dsr ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

    // Sign correction uses only the flags latched at start.
    assign q_fix = (sgn_q && (neg_dvd_q ^ neg_dsr_q)) ? (~quo_q + WIDTH'(1)) : quo_q;
    assign r_fix = (sgn_q && neg_dvd_q) ? (~rem_q + WIDTH'(1)) : rem_q;

    assign rem_chain[0] = rem_q;

    generate
        for (genvar i = 0; i < BPC; i++) begin : g_step
            div_step #(.WIDTH(WIDTH)) u_step (
                .rem      (rem_chain[i]),
                .bit_in   (dvd_q[WIDTH-1-i]),
                .divisor  (dsr_q),
                .rem_next (rem_chain[i+1]),
                .q_bit    (qbits[BPC-1-i])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        sgn_d       = sgn_q;
        neg_dvd_d   = neg_dvd_q;
        neg_dsr_d   = neg_dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = ready_q;
        zero_d      = zero_q;

        case (state_q)
            DIV_IDLE: begin
                if ((bus.start == DIV_START) && !bus.annul) begin
                    sgn_d     = bus.is_signed;
                    neg_dvd_d = in_neg_dvd;
                    neg_dsr_d = in_neg_dsr;
                    dvd_d     = in_dvd_mag;
                    dsr_d     = in_dsr_mag;
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = '0;
                    state_d   = (bus.divisor == '0) ? DIV_ZERO : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_chain[BPC];
                    dvd_d = dvd_q << BPC;
                    quo_d = (quo_q << BPC) | WIDTH'(qbits);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = DIV_FIX;
                    end
                end
            end
            DIV_FIX: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end else begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    zero_d      = 1'b0;
                    ready_d     = DIV_READY;
                    state_d     = DIV_DONE;
                end
            end
            DIV_ZERO: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end else begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    zero_d      = 1'b1;
                    ready_d     = DIV_READY;
                    state_d     = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (bus.ack) begin
                    quotient_d  = '0;
                    remainder_d = '0;
                    zero_d      = 1'b0;
                    ready_d     = DIV_NOT_READY;
                    state_d     = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        busy_d = (state_d != DIV_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DIV_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            sgn_q       <= 1'b0;
            neg_dvd_q   <= 1'b0;
            neg_dsr_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= DIV_NOT_READY;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            sgn_q       <= sgn_d;
            neg_dvd_q   <= neg_dvd_d;
            neg_dsr_q   <= neg_dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ready     = ready_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = zero_q;
endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param: BPC=1, 2 and 4 builds side by side.
module tb_div_iter_param;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    div_iter_param_if #(.WIDTH(32)) if1 ();
    div_iter_param_if #(.WIDTH(32)) if2 ();
    div_iter_param_if #(.WIDTH(32)) if4 ();

    div_iter_param #(.WIDTH(32), .BPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    div_iter_param #(.WIDTH(32), .BPC(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    div_iter_param #(.WIDTH(32), .BPC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic set_in(input int sel, input logic st, input logic sg, input logic an,
                          input logic ak, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            1: begin if1.start = st; if1.is_signed = sg; if1.annul = an; if1.ack = ak;
                     if1.dividend = a; if1.divisor = b; end
            2: begin if2.start = st; if2.is_signed = sg; if2.annul = an; if2.ack = ak;
                     if2.dividend = a; if2.divisor = b; end
            4: begin if4.start = st; if4.is_signed = sg; if4.annul = an; if4.ack = ak;
                     if4.dividend = a; if4.divisor = b; end
            default: ;
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            1: return if1.ready;
            2: return if2.ready;
            default: return if4.ready;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1: return if1.busy;
            2: return if2.busy;
            default: return if4.busy;
        endcase
    endfunction

    function automatic logic get_dz(input int sel);
        case (sel)
            1: return if1.div_zero;
            2: return if2.div_zero;
            default: return if4.div_zero;
        endcase
    endfunction

    function automatic logic [31:0] get_q(input int sel);
        case (sel)
            1: return if1.quotient;
            2: return if2.quotient;
            default: return if4.quotient;
        endcase
    endfunction

    function automatic logic [31:0] get_r(input int sel);
        case (sel)
            1: return if1.remainder;
            2: return if2.remainder;
            default: return if4.remainder;
        endcase
    endfunction

    // Issue one request; lat = edges after the accepting edge until ready is seen.
    task automatic run_op(input int sel, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
        @(negedge clk);
        set_in(sel, 1'b1, sg, 1'b0, 1'b0, a, b);
        @(posedge clk);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (get_ready(sel) !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_ack(input int sel);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 0, 32'd0, 32'd0);
        set_in(2, 0, 0, 0, 0, 32'd0, 32'd0);
        set_in(4, 0, 0, 0, 0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (if1.busy !== 1'b0) begin miscompares++;
            $display("FAIL reset busy: got %b want 0", if1.busy); end
        vectors++; if (if1.ready !== 1'b0) begin miscompares++;
            $display("FAIL reset ready: got %b want 0", if1.ready); end
        vectors++; if (if1.div_zero !== 1'b0) begin miscompares++;
            $display("FAIL reset div_zero: got %b want 0", if1.div_zero); end
        vectors++; if (if1.quotient !== 32'd0) begin miscompares++;
            $display("FAIL reset quotient: got %h want 0", if1.quotient); end
        vectors++; if (if1.remainder !== 32'd0) begin miscompares++;
            $display("FAIL reset remainder: got %h want 0", if1.remainder); end
    endtask

    task automatic test_unsigned();
        int lat;
        run_op(1, 1'b0, 32'd100, 32'd7, lat);
        vectors++; if (lat !== 33) begin miscompares++;
            $display("FAIL u100_7 latency: got %0d want 33", lat); end
        vectors++; if (if1.quotient !== 32'd14) begin miscompares++;
            $display("FAIL u100_7 quotient: got %h want %h", if1.quotient, 32'd14); end
        vectors++; if (if1.remainder !== 32'd2) begin miscompares++;
            $display("FAIL u100_7 remainder: got %h want %h", if1.remainder, 32'd2); end
        vectors++; if (if1.div_zero !== 1'b0) begin miscompares++;
            $display("FAIL u100_7 div_zero: got %b want 0", if1.div_zero); end
        // DONE must ignore annul and start and hold the result.
        repeat (3) @(negedge clk);
        set_in(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'd50, 32'd5);
        @(posedge clk);
        @(negedge clk);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        vectors++; if (if1.ready !== 1'b1) begin miscompares++;
            $display("FAIL done_hold ready: got %b want 1", if1.ready); end
        vectors++; if (if1.quotient !== 32'd14) begin miscompares++;
            $display("FAIL done_hold quotient: got %h want %h", if1.quotient, 32'd14); end
        do_ack(1);
        vectors++; if (if1.ready !== 1'b0) begin miscompares++;
            $display("FAIL ack ready: got %b want 0", if1.ready); end
        vectors++; if (if1.quotient !== 32'd0) begin miscompares++;
            $display("FAIL ack quotient: got %h want 0", if1.quotient); end
        vectors++; if (if1.remainder !== 32'd0) begin miscompares++;
            $display("FAIL ack remainder: got %h want 0", if1.remainder); end
        vectors++; if (if1.busy !== 1'b0) begin miscompares++;
            $display("FAIL ack busy: got %b want 0", if1.busy); end
    endtask

    task automatic test_signed();
        int lat;
        run_op(1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        vectors++; if (if1.quotient !== 32'hFFFF_FFFD) begin miscompares++;
            $display("FAIL s-7_2 quotient: got %h want FFFFFFFD", if1.quotient); end
        vectors++; if (if1.remainder !== 32'hFFFF_FFFF) begin miscompares++;
            $display("FAIL s-7_2 remainder: got %h want FFFFFFFF", if1.remainder); end
        do_ack(1);
        run_op(1, 1'b1, 32'd7, 32'hFFFF_FFFE, lat);
        vectors++; if (if1.quotient !== 32'hFFFF_FFFD) begin miscompares++;
            $display("FAIL s7_-2 quotient: got %h want FFFFFFFD", if1.quotient); end
        vectors++; if (if1.remainder !== 32'd1) begin miscompares++;
            $display("FAIL s7_-2 remainder: got %h want 00000001", if1.remainder); end
        do_ack(1);
        run_op(1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat);
        vectors++; if (if1.quotient !== 32'd3) begin miscompares++;
            $display("FAIL s-7_-2 quotient: got %h want 00000003", if1.quotient); end
        vectors++; if (if1.remainder !== 32'hFFFF_FFFF) begin miscompares++;
            $display("FAIL s-7_-2 remainder: got %h want FFFFFFFF", if1.remainder); end
        do_ack(1);
    endtask

    task automatic test_min_overflow();
        int lat;
        run_op(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        vectors++; if (if1.quotient !== 32'h8000_0000) begin miscompares++;
            $display("FAIL smin quotient: got %h want 80000000", if1.quotient); end
        vectors++; if (if1.remainder !== 32'd0) begin miscompares++;
            $display("FAIL smin remainder: got %h want 0", if1.remainder); end
        vectors++; if (if1.div_zero !== 1'b0) begin miscompares++;
            $display("FAIL smin div_zero: got %b want 0", if1.div_zero); end
        do_ack(1);
        run_op(1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        vectors++; if (if1.quotient !== 32'd0) begin miscompares++;
            $display("FAIL umin quotient: got %h want 0", if1.quotient); end
        vectors++; if (if1.remainder !== 32'h8000_0000) begin miscompares++;
            $display("FAIL umin remainder: got %h want 80000000", if1.remainder); end
        do_ack(1);
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(1, 1'b0, 32'h0000_1234, 32'd0, lat);
        vectors++; if (lat !== 1) begin miscompares++;
            $display("FAIL dz latency: got %0d want 1", lat); end
        vectors++; if (if1.div_zero !== 1'b1) begin miscompares++;
            $display("FAIL dz flag: got %b want 1", if1.div_zero); end
        vectors++; if (if1.quotient !== 32'd0) begin miscompares++;
            $display("FAIL dz quotient: got %h want 0", if1.quotient); end
        vectors++; if (if1.remainder !== 32'd0) begin miscompares++;
            $display("FAIL dz remainder: got %h want 0", if1.remainder); end
        do_ack(1);
        vectors++; if (if1.busy !== 1'b0) begin miscompares++;
            $display("FAIL dz ack busy: got %b want 0", if1.busy); end
        vectors++; if (if1.div_zero !== 1'b0) begin miscompares++;
            $display("FAIL dz ack flag: got %b want 0", if1.div_zero); end
    endtask

    task automatic test_annul();
        int   lat;
        logic seen;
        @(negedge clk);
        set_in(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        @(negedge clk);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(negedge clk);
        vectors++; if (if1.busy !== 1'b1) begin miscompares++;
            $display("FAIL annul pre busy: got %b want 1", if1.busy); end
        set_in(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        vectors++; if (if1.busy !== 1'b0) begin miscompares++;
            $display("FAIL annul busy: got %b want 0", if1.busy); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if1.ready === 1'b1) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++;
            $display("FAIL annul ready_seen: got %b want 0", seen); end
        run_op(1, 1'b0, 32'd9, 32'd3, lat);
        vectors++; if (if1.quotient !== 32'd3) begin miscompares++;
            $display("FAIL post_annul quotient: got %h want 3", if1.quotient); end
        vectors++; if (if1.remainder !== 32'd0) begin miscompares++;
            $display("FAIL post_annul remainder: got %h want 0", if1.remainder); end
        do_ack(1);
    endtask

    task automatic test_bpc(input int sel, input int exp_lat);
        int lat;
        run_op(sel, 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, lat);
        vectors++; if (lat !== exp_lat) begin miscompares++;
            $display("FAIL bpc%0d latency: got %0d want %0d", sel, lat, exp_lat); end
        vectors++; if (get_q(sel) !== 32'h0FFF_FFFF) begin miscompares++;
            $display("FAIL bpc%0d quotient: got %h want 0FFFFFFF", sel, get_q(sel)); end
        vectors++; if (get_r(sel) !== 32'h0000_000F) begin miscompares++;
            $display("FAIL bpc%0d remainder: got %h want 0000000F", sel, get_r(sel)); end
        do_ack(sel);
        run_op(sel, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        vectors++; if (get_q(sel) !== 32'hFFFF_FFFD) begin miscompares++;
            $display("FAIL bpc%0d signed quotient: got %h want FFFFFFFD", sel, get_q(sel)); end
        vectors++; if (get_r(sel) !== 32'hFFFF_FFFF) begin miscompares++;
            $display("FAIL bpc%0d signed remainder: got %h want FFFFFFFF", sel, get_r(sel)); end
        do_ack(sel);
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        @(negedge clk);
        set_in(2, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        set_in(4, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        @(negedge clk);
        set_in(2, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_in(4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        vectors++; if (if4.busy !== 1'b1) begin miscompares++;
            $display("FAIL midrst pre busy: got %b want 1", if4.busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 2; s <= 4; s += 2) begin
            vectors++; if (get_busy(s) !== 1'b0) begin miscompares++;
                $display("FAIL midrst bpc%0d busy: got %b want 0", s, get_busy(s)); end
            vectors++; if (get_ready(s) !== 1'b0) begin miscompares++;
                $display("FAIL midrst bpc%0d ready: got %b want 0", s, get_ready(s)); end
            vectors++; if (get_dz(s) !== 1'b0) begin miscompares++;
                $display("FAIL midrst bpc%0d div_zero: got %b want 0", s, get_dz(s)); end
            vectors++; if ({get_q(s), get_r(s)} !== 64'd0) begin miscompares++;
                $display("FAIL midrst bpc%0d results: got %h_%h want 0", s, get_q(s), get_r(s)); end
        end
        run_op(4, 1'b0, 32'd100, 32'd7, lat);
        vectors++; if (lat !== 9) begin miscompares++;
            $display("FAIL midrst after latency: got %0d want 9", lat); end
        vectors++; if ({if4.quotient, if4.remainder} !== {32'd14, 32'd2}) begin miscompares++;
            $display("FAIL midrst after result: got %h_%h want 0000000e_00000002",
                     if4.quotient, if4.remainder); end
        do_ack(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_min_overflow();
        test_div_zero();
        test_annul();
        test_bpc(2, 17);
        test_bpc(4, 9);
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
